// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package xr_mem_pkg;

    localparam int AW_DEFAULT   = 32;
    localparam int DW_DEFAULT   = 32;
    localparam int STARVE_CNT_W = 4;

    // Owner of the read whose data is on mem_rdata this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// master = the arbiter itself, slave = core ports plus SRAM.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic            d_req;
    logic [AW-1:0]   d_addr;
    logic            d_wr_en;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_addr, d_wr_en, d_be, d_wdata,
               mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wr_en, mem_be, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_addr, d_wr_en, d_be, d_wdata,
               mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wr_en, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating counter of consecutive data grants taken while fetch waits.
import xr_mem_pkg::*;

module starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_reg;
    logic [STARVE_CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg < LIMIT_V)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt      = cnt_reg;
    assign at_limit = (cnt_reg >= LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port SRAM with 1-cycle read latency.
// Data has priority; a starvation counter hands fetch a slot after STARVE_MAX data grants.
import xr_mem_pkg::*;

module mem_arbiter #(
    parameter int AW         = AW_DEFAULT,
    parameter int DW         = DW_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int BW = DW / 8;

    logic                    fetch_win;
    logic                    data_win;
    logic                    starve_at_limit;
    logic [STARVE_CNT_W-1:0] starve_val;
    logic [AW-1:0]           sel_addr;
    mem_owner_t              resp_own_reg;
    mem_owner_t              resp_own_next;

    // Requests are combinational into grants, so reset must mask them here.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (!rst) begin
            fetch_win = bus.if_req && (!bus.d_req || starve_at_limit);
            data_win  = bus.d_req && !fetch_win;
        end
    end

    assign sel_addr      = fetch_win ? bus.if_addr : bus.d_addr;
    assign bus.mem_en    = fetch_win || data_win;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wr_en = data_win && bus.d_wr_en;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_gnt    = fetch_win && bus.mem_ready;
    assign bus.d_gnt     = data_win && bus.mem_ready;

    genvar gi;
    generate
        for (gi = 0; gi < BW; gi++) begin : g_be
            assign bus.mem_be[gi] = fetch_win || bus.d_be[gi];
        end
    endgenerate

    starve_cnt #(
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.if_gnt || !bus.if_req),
        .inc      (bus.d_gnt && bus.if_req),
        .cnt      (starve_val),
        .at_limit (starve_at_limit)
    );

    // Response-owner tracker: state register, next state, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_own_reg <= OWN_NONE;
        end else begin
            resp_own_reg <= resp_own_next;
        end
    end

    always_comb begin
        resp_own_next = OWN_NONE;
        if (bus.if_gnt) begin
            resp_own_next = OWN_IF;
        end else if (bus.d_gnt && !bus.d_wr_en) begin
            resp_own_next = OWN_D;
        end
    end

    // rst also masks rvalid so a read granted just before reset is dropped.
    always_comb begin
        bus.if_rvalid = (resp_own_reg == OWN_IF) && !rst;
        bus.d_rvalid  = (resp_own_reg == OWN_D) && !rst;
        bus.if_rdata  = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/responses with
// their cycle numbers; a negedge monitor pops and compares them.
import xr_mem_pkg::*;

module tb_mem_arbiter;

    localparam logic [31:0] RD_100 = 32'hDEAD_BEEF;
    localparam logic [31:0] RD_200 = 32'hA5A5_0200;
    localparam logic [31:0] RD_300 = 32'hA5A5_0300;

    typedef struct {
        mem_owner_t  own;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t gq[$];
    exp_t rq[$];

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: contents are a fixed function of the address.
    function automatic logic [31:0] rdata_of(logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {16'hA5A5, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_ready && !bus.mem_wr_en)
            bus.mem_rdata <= rdata_of(bus.mem_addr);
        else
            bus.mem_rdata <= 32'h0BAD_0BAD;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_g(mem_owner_t o, logic [31:0] a, int c);
        gq.push_back('{own: o, val: a, cyc: c});
    endtask

    task automatic push_r(mem_owner_t o, logic [31:0] d, int c);
        rq.push_back('{own: o, val: d, cyc: c});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        mem_owner_t o;
        exp_t e;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            e = gq.pop_front();
            checks++; failures++;
            $display("FAIL missed_gnt actual=none required=own%0d@%0d", e.own, e.cyc);
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            e = rq.pop_front();
            checks++; failures++;
            $display("FAIL missed_rvalid actual=none required=own%0d@%0d", e.own, e.cyc);
        end
        if (bus.if_gnt && bus.d_gnt) begin
            checks++; failures++;
            $display("FAIL dual_gnt actual=both required=one (cycle %0d)", cyc);
        end else if (bus.if_gnt || bus.d_gnt) begin
            o = bus.if_gnt ? OWN_IF : OWN_D;
            $display("TXN gnt cyc=%0d own=%0d addr=%h we=%0d", cyc, o, bus.mem_addr, bus.mem_wr_en);
            if (gq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_gnt actual=own%0d required=none (cycle %0d)", o, cyc);
            end else begin
                e = gq.pop_front();
                check("gnt_cycle", 32'(cyc), 32'(e.cyc));
                check("gnt_owner", 32'(o), 32'(e.own));
                check("gnt_addr", bus.mem_addr, e.val);
            end
        end
        if (bus.if_rvalid && bus.d_rvalid) begin
            checks++; failures++;
            $display("FAIL dual_rvalid actual=both required=one (cycle %0d)", cyc);
        end else if (bus.if_rvalid || bus.d_rvalid) begin
            o = bus.if_rvalid ? OWN_IF : OWN_D;
            $display("TXN rsp cyc=%0d own=%0d data=%h", cyc, o,
                     bus.if_rvalid ? bus.if_rdata : bus.d_rdata);
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rvalid actual=own%0d required=none (cycle %0d)", o, cyc);
            end else begin
                e = rq.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                check("rsp_owner", 32'(o), 32'(e.own));
                check("rsp_data", bus.if_rvalid ? bus.if_rdata : bus.d_rdata, e.val);
            end
        end
    end

    initial begin
        int c;
        mem_owner_t o;

        rst           = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h200;
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h300;
        bus.d_wr_en   = 1'b0;
        bus.d_be      = 4'hF;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b1;

        // Reset with both requests pending
        repeat (3) begin
            @(negedge clk);
            check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
            check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
            check("rst_mem_en", 32'(bus.mem_en), 32'd0);
            check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: D,D,D,D,IF,D,D,D,D,IF then fetch drops, last D
        c = cyc;
        for (int k = 0; k <= 10; k++) begin
            o = (k == 4 || k == 9) ? OWN_IF : OWN_D;
            push_g(o, (o == OWN_IF) ? 32'h200 : 32'h300, c + k);
            push_r(o, (o == OWN_IF) ? RD_200 : RD_300, c + k + 1);
        end
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) bus.if_req = 1'b0;
            @(negedge clk);
            if (k == 0) check("first_d_gnt", 32'(bus.d_gnt), 32'd1);
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0;

        // Solo fetch
        @(posedge clk); #1;
        c = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        push_g(OWN_IF, 32'h100, c);
        push_r(OWN_IF, RD_100, c + 1);
        @(negedge clk);
        check("solo_if_gnt", 32'(bus.if_gnt), 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);
        check("solo_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("solo_if_rdata", bus.if_rdata, RD_100);
        check("solo_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        // Data write
        @(posedge clk); #1;
        c = cyc;
        bus.d_req   = 1'b1;
        bus.d_wr_en = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_be    = 4'b0011;
        bus.d_wdata = 32'h1234_5678;
        push_g(OWN_D, 32'h40, c);
        @(negedge clk);
        check("wr_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("wr_mem_wr_en", 32'(bus.mem_wr_en), 32'd1);
        check("wr_mem_be", 32'(bus.mem_be), 32'h3);
        check("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        @(posedge clk); #1;
        bus.d_req   = 1'b0;
        bus.d_wr_en = 1'b0;
        bus.d_addr  = 32'h300;
        bus.d_be    = 4'hF;
        @(negedge clk);
        check("wr_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        // Wait states with both requests pending (count = 1 going in)
        @(posedge clk); #1;
        c = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req   = 1'b1;
        push_g(OWN_D, 32'h300, c);     push_r(OWN_D, RD_300, c + 1);
        push_g(OWN_D, 32'h300, c + 3); push_r(OWN_D, RD_300, c + 4);
        push_g(OWN_D, 32'h300, c + 4); push_r(OWN_D, RD_300, c + 5);
        push_g(OWN_D, 32'h300, c + 5); push_r(OWN_D, RD_300, c + 6);
        push_g(OWN_IF, 32'h200, c + 6); push_r(OWN_IF, RD_200, c + 7);
        push_g(OWN_D, 32'h300, c + 7); push_r(OWN_D, RD_300, c + 8);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("ws_if_gnt", 32'(bus.if_gnt), 32'd0);
            check("ws_d_gnt", 32'(bus.d_gnt), 32'd0);
            check("ws_mem_en", 32'(bus.mem_en), 32'd1);
            check("ws_starve_cnt", 32'(dut.u_starve.cnt), 32'd1);
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("ws_resume_d_gnt", 32'(bus.d_gnt), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        bus.d_req = 1'b0;

        // Reset in the cycle after a granted data read
        @(posedge clk); #1;
        c = cyc;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        push_g(OWN_D, 32'h300, c);
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("postrst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("postrst_starve_cnt", 32'(dut.u_starve.cnt), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("gnt_queue_empty", 32'(gq.size()), 32'd0);
        check("rsp_queue_empty", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
